// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB (no PREADY) master bridge, four 64 MB APB slots at 0x8000_0000-0x8FFF_FFFF.
// Optional macro AHB_ERR_RESP_EN: out-of-window transfers get a two-cycle ERROR response instead of being dropped.
`timescale 1ns/1ps
module ahb_apb_bridge (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Haddr,
    input  logic [1:0]  Htrans,
    input  logic        Hwrite,
    input  logic [31:0] Hwdata,
    input  logic        Hreadyin,
    output logic        Hreadyout,
    output logic [1:0]  Hresp,
    output logic [31:0] Hrdata,
    output logic [3:0]  Pselx,
    output logic        Penable,
    output logic        Pwrite,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    input  logic [31:0] Prdata
);

`ifdef AHB_ERR_RESP_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_WWAIT, ST_RSETUP, ST_RENABLE, ST_WSETUP, ST_WENABLE, ST_ERR1, ST_ERR2
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_WWAIT, ST_RSETUP, ST_RENABLE, ST_WSETUP, ST_WENABLE
    } state_t;
`endif

    state_t      r_state;
    logic [31:0] r_addr;
    logic        w_valid;
    logic        w_in_win;
    logic [3:0]  w_sel_haddr;
    logic [3:0]  w_sel_raddr;
    logic        w_unused_htrans;

    function automatic logic [3:0] slot_decode(input logic [1:0] slot);
        return 4'b0001 << slot;
    endfunction

    assign w_unused_htrans = Htrans[0];
    assign w_in_win        = (Haddr[31:28] == 4'b1000);
    assign w_sel_haddr     = slot_decode(Haddr[27:26]);
    assign w_sel_raddr     = slot_decode(r_addr[27:26]);
    assign w_valid         = Htrans[1] & Hreadyin & Hreadyout;

`ifdef AHB_ERR_RESP_EN
    assign Hreadyout = (r_state == ST_IDLE) || (r_state == ST_ERR2);
    assign Hresp     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? 2'b01 : 2'b00;
`else
    assign Hreadyout = (r_state == ST_IDLE);
    assign Hresp     = 2'b00;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= 32'h0;
            Hrdata  <= 32'h0;
            Pselx   <= 4'h0;
            Penable <= 1'b0;
            Pwrite  <= 1'b0;
            Paddr   <= 32'h0;
            Pwdata  <= 32'h0;
        end else if (Hreadyout) begin
            // IDLE and ERR2 both sample a new address phase
            if (w_valid && w_in_win && !Hwrite) begin
                r_state <= ST_RSETUP;
                r_addr  <= Haddr;
                Pselx   <= w_sel_haddr;
                Paddr   <= Haddr;
                Pwrite  <= 1'b0;
                Penable <= 1'b0;
            end else if (w_valid && w_in_win && Hwrite) begin
                r_state <= ST_WWAIT;
                r_addr  <= Haddr;
`ifdef AHB_ERR_RESP_EN
            end else if (w_valid) begin
                r_state <= ST_ERR1;
`endif
            end else begin
                r_state <= ST_IDLE;
            end
        end else begin
            case (r_state)
                ST_WWAIT: begin
                    r_state <= ST_WSETUP;
                    Pselx   <= w_sel_raddr;
                    Paddr   <= r_addr;
                    Pwrite  <= 1'b1;
                    Pwdata  <= Hwdata;
                    Penable <= 1'b0;
                end
                ST_RSETUP: begin
                    r_state <= ST_RENABLE;
                    Penable <= 1'b1;
                end
                ST_RENABLE: begin
                    r_state <= ST_IDLE;
                    Hrdata  <= Prdata;
                    Pselx   <= 4'h0;
                    Penable <= 1'b0;
                end
                ST_WSETUP: begin
                    r_state <= ST_WENABLE;
                    Penable <= 1'b1;
                end
                ST_WENABLE: begin
                    r_state <= ST_IDLE;
                    Pselx   <= 4'h0;
                    Penable <= 1'b0;
                end
`ifdef AHB_ERR_RESP_EN
                ST_ERR1: r_state <= ST_ERR2;
`endif
                default: begin
                    r_state <= ST_IDLE;
                    Pselx   <= 4'h0;
                    Penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Bench for ahb_apb_bridge: transaction-age reference model checked every cycle, plus directed literal cases.
`timescale 1ns/1ps
module tb_ahb_apb_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] Haddr;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic [31:0] Hwdata;
    logic        Hreadyin;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;
    logic [3:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;

    ahb_apb_bridge dut (
        .clock(clock), .reset(reset), .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite),
        .Hwdata(Hwdata), .Hreadyin(Hreadyin), .Hreadyout(Hreadyout), .Hresp(Hresp),
        .Hrdata(Hrdata), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one in-flight transaction tracked by kind and cycles since acceptance.
    localparam int K_RD = 0;
    localparam int K_WR = 1;
    localparam int K_ER = 2;

    logic        m_busy;
    int          m_kind;
    int          m_age;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_hrdata;

    function automatic logic in_window(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a <= 32'h8FFF_FFFF);
    endfunction

    function automatic logic [3:0] sel_of(input logic [31:0] a);
        int idx;
        idx = int'((a - 32'h8000_0000) / 32'h0400_0000);
        return 4'(1 << idx);
    endfunction

    function automatic int last_age(input int kind);
        return (kind == K_WR) ? 3 : 2;
    endfunction

    function automatic logic exp_ready();
        return !m_busy || (m_kind == K_ER && m_age == 2);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy   <= 1'b0;
            m_kind   <= K_RD;
            m_age    <= 0;
            m_addr   <= 32'h0;
            m_wdata  <= 32'h0;
            m_hrdata <= 32'h0;
        end else begin
            if (m_busy && m_kind == K_WR && m_age == 1) m_wdata  <= Hwdata;
            if (m_busy && m_kind == K_RD && m_age == 2) m_hrdata <= Prdata;
            if (Htrans[1] && Hreadyin && exp_ready()) begin
                if (in_window(Haddr)) begin
                    m_busy <= 1'b1;
                    m_kind <= Hwrite ? K_WR : K_RD;
                    m_age  <= 1;
                    m_addr <= Haddr;
                end else begin
`ifdef AHB_ERR_RESP_EN
                    m_busy <= 1'b1;
                    m_kind <= K_ER;
                    m_age  <= 1;
`else
                    m_busy <= 1'b0;
`endif
                end
            end else if (m_busy && m_age < last_age(m_kind)) begin
                m_age <= m_age + 1;
            end else begin
                m_busy <= 1'b0;
            end
        end
    end

    task automatic compare();
        logic       apb;
        logic       en;
        apb = m_busy && ((m_kind == K_RD) || (m_kind == K_WR && m_age >= 2));
        en  = apb && (m_age == last_age(m_kind));
        chk("Hreadyout", 32'(Hreadyout), 32'(exp_ready()));
        chk("Hresp",     32'(Hresp),     (m_busy && m_kind == K_ER) ? 32'h1 : 32'h0);
        chk("Hrdata",    Hrdata,         m_hrdata);
        chk("Pselx",     32'(Pselx),     apb ? 32'(sel_of(m_addr)) : 32'h0);
        chk("Penable",   32'(Penable),   32'(en));
        if (apb) begin
            chk("Paddr",  Paddr,         m_addr);
            chk("Pwrite", 32'(Pwrite),   (m_kind == K_WR) ? 32'h1 : 32'h0);
            if (m_kind == K_WR) chk("Pwdata", Pwdata, m_wdata);
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        compare();
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic w);
        Haddr  = a;
        Htrans = t;
        Hwrite = w;
    endtask

    initial begin
        logic [31:0] base;
        reset    = 1'b1;
        Haddr    = 32'h0;
        Htrans   = 2'b00;
        Hwrite   = 1'b0;
        Hwdata   = 32'h0;
        Hreadyin = 1'b1;
        Prdata   = 32'h0;
        cycle();
        cycle();
        chk("rst_hreadyout", 32'(Hreadyout), 32'h1);
        chk("rst_pselx",     32'(Pselx),     32'h0);
        chk("rst_hrdata",    Hrdata,         32'h0);
        reset = 1'b0;
        cycle();

        // Read at slot 0
        drive(32'h8000_0010, 2'b10, 1'b0);
        Prdata = 32'hDEAD_BEEF;
        cycle();
        drive(32'h0, 2'b00, 1'b0);
        chk("rd_setup_pselx",   32'(Pselx),     32'h1);
        chk("rd_setup_paddr",   Paddr,          32'h8000_0010);
        chk("rd_setup_pwrite",  32'(Pwrite),    32'h0);
        chk("rd_setup_penable", 32'(Penable),   32'h0);
        chk("rd_setup_ready",   32'(Hreadyout), 32'h0);
        cycle();
        chk("rd_enable_penable", 32'(Penable),  32'h1);
        cycle();
        chk("rd_done_ready",  32'(Hreadyout), 32'h1);
        chk("rd_done_hrdata", Hrdata,         32'hDEAD_BEEF);
        chk("rd_done_pselx",  32'(Pselx),     32'h0);

        // Write at slot 1
        drive(32'h8400_0004, 2'b10, 1'b1);
        cycle();
        drive(32'h0, 2'b00, 1'b0);
        Hwdata = 32'h1234_5678;
        chk("wr_wait_ready", 32'(Hreadyout), 32'h0);
        chk("wr_wait_pselx", 32'(Pselx),     32'h0);
        cycle();
        Hwdata = 32'hFFFF_0000;
        chk("wr_setup_pselx",  32'(Pselx),  32'h2);
        chk("wr_setup_pwrite", 32'(Pwrite), 32'h1);
        chk("wr_setup_pwdata", Pwdata,      32'h1234_5678);
        cycle();
        chk("wr_enable_penable", 32'(Penable), 32'h1);
        cycle();
        chk("wr_done_ready", 32'(Hreadyout), 32'h1);

        // Back-to-back read slot 2 then write slot 3; write address held until ready
        drive(32'h8800_0000, 2'b10, 1'b0);
        Prdata = 32'hA5A5_0001;
        cycle();
        drive(32'h8C00_0000, 2'b10, 1'b1);
        chk("b2b_rd_pselx", 32'(Pselx), 32'h4);
        cycle();
        cycle();
        chk("b2b_idle_pselx", 32'(Pselx),     32'h0);
        chk("b2b_idle_ready", 32'(Hreadyout), 32'h1);
        cycle();
        drive(32'h0, 2'b00, 1'b0);
        Hwdata = 32'h0BAD_F00D;
        cycle();
        chk("b2b_wr_pselx",  32'(Pselx), 32'h8);
        chk("b2b_wr_pwdata", Pwdata,     32'h0BAD_F00D);
        cycle();
        cycle();

        // Non-transfers must not start APB activity
        drive(32'h8000_0000, 2'b00, 1'b0);
        cycle();
        cycle();
        chk("idle_htrans_pselx", 32'(Pselx), 32'h0);
        drive(32'h8000_0000, 2'b10, 1'b0);
        Hreadyin = 1'b0;
        cycle();
        cycle();
        chk("hreadyin0_pselx", 32'(Pselx),     32'h0);
        chk("hreadyin0_ready", 32'(Hreadyout), 32'h1);
        Hreadyin = 1'b1;
        drive(32'h0, 2'b00, 1'b0);
        cycle();

        // Out-of-window access
        drive(32'h9000_0000, 2'b10, 1'b0);
        cycle();
        drive(32'h0, 2'b00, 1'b0);
`ifdef AHB_ERR_RESP_EN
        chk("err1_hresp", 32'(Hresp),     32'h1);
        chk("err1_ready", 32'(Hreadyout), 32'h0);
        cycle();
        chk("err2_hresp", 32'(Hresp),     32'h1);
        chk("err2_ready", 32'(Hreadyout), 32'h1);
`else
        chk("oow_hresp", 32'(Hresp),     32'h0);
        chk("oow_ready", 32'(Hreadyout), 32'h1);
        cycle();
`endif
        chk("oow_pselx", 32'(Pselx), 32'h0);
        cycle();

        // Reset asserted during WENABLE
        drive(32'h8400_0008, 2'b10, 1'b1);
        Hwdata = 32'h5555_AAAA;
        cycle();
        drive(32'h0, 2'b00, 1'b0);
        cycle();
        cycle();
        chk("pre_rst_penable", 32'(Penable), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ready",   32'(Hreadyout), 32'h1);
        chk("mid_rst_pselx",   32'(Pselx),     32'h0);
        chk("mid_rst_penable", 32'(Penable),   32'h0);
        chk("mid_rst_pwrite",  32'(Pwrite),    32'h0);
        chk("mid_rst_paddr",   Paddr,          32'h0);
        chk("mid_rst_pwdata",  Pwdata,         32'h0);
        chk("mid_rst_hrdata",  Hrdata,         32'h0);
        chk("mid_rst_hresp",   32'(Hresp),     32'h0);
        cycle();
        reset = 1'b0;
        cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 6))
                0: base = 32'h8000_0000;
                1: base = 32'h8400_0000;
                2: base = 32'h8800_0000;
                3: base = 32'h8C00_0000;
                4: base = 32'h9000_0000;
                5: base = 32'h0000_0000;
                default: base = $urandom;
            endcase
            Haddr    = base | ($urandom & 32'h03FF_FFFC);
            Htrans   = 2'($urandom_range(0, 3));
            Hwrite   = 1'($urandom_range(0, 1));
            Hreadyin = ($urandom_range(0, 9) != 0);
            Hwdata   = $urandom;
            Prdata   = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
